// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_capture_pkg                                                 |
// | Purpose  : Shared definitions for the PWM capture block: pi1 bus op codes, |
// |            write-command codes, RW read-selector codes, channel state      |
// |            encoding and a constant-evaluable clog2 helper.                 |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pwm_capture_pkg;

    // pi1 bus operations
    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    // Write commands (data_i[1:0] of a WR)
    localparam logic [1:0] CMD_SELECT = 2'b00;
    localparam logic [1:0] CMD_CLEAR  = 2'b01;

    // Read selectors (data_i[1:0] of a RW)
    localparam logic [1:0] RWSEL_PERIOD = 2'b00;
    localparam logic [1:0] RWSEL_HIGH   = 2'b01;
    localparam logic [1:0] RWSEL_STATUS = 2'b10;
    localparam logic [1:0] RWSEL_ZERO   = 2'b11;

    // Per-channel measurement state
    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_capture_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_capture_chan                                                |
// | Purpose  : One capture channel. Synchronises an asynchronous PWM input,    |
// |            detects edges and measures period and high time in clk cycles. |
// | Ports    : clk_i      clock                                               |
// |            rst_i      asynchronous active-low reset                       |
// |            pwm_i      asynchronous PWM input                              |
// |            clr_i      clear ovf/valid and force WAIT                      |
// |            ovf_clr_i  clear sticky overflow (a new overflow wins)         |
// |            level_o    synchronised input level                            |
// |            run_o      channel is measuring                                |
// |            valid_o    period/high hold a complete measurement             |
// |            ovf_o      sticky overflow flag                                |
// |            period_o   last measured period                                |
// |            high_o     last measured high time                             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pwm_capture_chan
    import pwm_capture_pkg::*;
#(
    parameter int CW = 30
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pwm_i,
    input  logic          clr_i,
    input  logic          ovf_clr_i,
    output logic          level_o,
    output logic          run_o,
    output logic          valid_o,
    output logic          ovf_o,
    output logic [CW-1:0] period_o,
    output logic [CW-1:0] high_o
);

    localparam logic [CW-1:0] c_CNT_MAX = '1;

    logic          sync1_q;
    logic          sync_q;
    logic          hist_q;
    chan_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] period_q;
    logic [CW-1:0] high_q;
    logic          valid_q;
    logic          ovf_q;

    logic          w_rise;
    logic          w_fall;
    logic          w_cnt_max;
    logic [CW-1:0] w_cnt_inc;

    assign w_rise    = sync_q & ~hist_q;
    assign w_fall    = ~sync_q & hist_q;
    assign w_cnt_max = (cnt_q == c_CNT_MAX);
    // cnt counts cycles since the rise minus one, so +1 gives the length
    assign w_cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q  <= 1'b0;
            sync_q   <= 1'b0;
            hist_q   <= 1'b0;
            state_q  <= ST_WAIT;
            cnt_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync_q  <= sync1_q;
            hist_q  <= sync_q;

            if (clr_i) begin
                state_q <= ST_WAIT;
                cnt_q   <= '0;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                // Status-read clear; any overflow set below overrides it
                if (ovf_clr_i) begin
                    ovf_q <= 1'b0;
                end

                case (state_q)
                    ST_WAIT: begin
                        cnt_q <= '0;
                        if (w_rise) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (w_rise) begin
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            if (w_cnt_max) begin
                                // Period would wrap: clamp and flag
                                period_q <= c_CNT_MAX;
                                ovf_q    <= 1'b1;
                            end else begin
                                period_q <= w_cnt_inc;
                            end
                        end else begin
                            if (w_fall) begin
                                high_q <= w_cnt_max ? c_CNT_MAX : w_cnt_inc;
                            end
                            if (w_cnt_max && !w_fall) begin
                                // Input stuck: abandon the measurement
                                state_q  <= ST_WAIT;
                                cnt_q    <= '0;
                                period_q <= '0;
                                high_q   <= '0;
                                valid_q  <= 1'b0;
                                ovf_q    <= 1'b1;
                            end else if (!w_cnt_max) begin
                                cnt_q <= w_cnt_inc;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_WAIT;
                    end
                endcase
            end
        end
    end

    assign level_o  = sync_q;
    assign run_o    = (state_q == ST_RUN);
    assign valid_o  = valid_q;
    assign ovf_o    = ovf_q;
    assign period_o = period_q;
    assign high_o   = high_q;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_capture                                                     |
// | Purpose  : Multi-channel PWM input decoder on the pi1 bus. Software picks  |
// |            a channel, then reads coherent period/high pairs and status.   |
// | Ports    : clk_i        clock                                             |
// |            rst_i        asynchronous active-low reset                     |
// |            pi1_op_i     bus op (NOP/WR/RD/RW)                             |
// |            pi1_addr_i   unused (single-word map)                          |
// |            pi1_data_i   command word                                      |
// |            pi1_data_o   registered response                               |
// |            pi1_sel_i    unused                                            |
// |            pi1_rdy_o    always ready                                      |
// |            pi1_mapsz_o  map size, one word                                |
// |            pwm_i        asynchronous PWM inputs                           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int PWM_COUNT = 8,
    parameter int CLKFREQ   = 1,
    parameter int ARCHBITSZ = 32,
    localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               pi1_op_i,
    input  logic [ADDRBITSZ-1:0]     pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]     pi1_data_i,
    output logic [ARCHBITSZ-1:0]     pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0]   pi1_sel_i,
    output logic                     pi1_rdy_o,
    output logic [ADDRBITSZ-1:0]     pi1_mapsz_o,
    input  logic [PWM_COUNT-1:0]     pwm_i
);

    localparam int c_CW    = ARCHBITSZ - 2;
    localparam int c_SELW  = (PWM_COUNT > 1) ? clog2(PWM_COUNT) : 1;
    localparam int c_NSLOT = 1 << c_SELW;
    localparam logic [ARCHBITSZ-1:0] c_CLKFREQ = ARCHBITSZ'(CLKFREQ);

    logic [c_SELW-1:0]    sel_q,    sel_d;
    logic [c_CW-1:0]      shadow_q, shadow_d;
    logic [ARCHBITSZ-1:0] data_q,   data_d;

    // Slot arrays are padded to a power of two so an out-of-range select
    // lands on a tied-off slot and reads zero.
    logic [c_NSLOT-1:0][c_CW-1:0] w_period;
    logic [c_NSLOT-1:0][c_CW-1:0] w_high;
    logic [c_NSLOT-1:0]           w_level;
    logic [c_NSLOT-1:0]           w_run;
    logic [c_NSLOT-1:0]           w_valid;
    logic [c_NSLOT-1:0]           w_ovf;
    logic [PWM_COUNT-1:0]         w_clr;
    logic [PWM_COUNT-1:0]         w_ovf_clr;

    logic w_clr_cmd;
    logic w_stat_rd;
    logic w_unused;

    assign w_clr_cmd = (pi1_op_i == PIWROP) && (pi1_data_i[1:0] == CMD_CLEAR);
    assign w_stat_rd = (pi1_op_i == PIRWOP) && (pi1_data_i[1:0] == RWSEL_STATUS);

    for (genvar gi = 0; gi < c_NSLOT; gi++) begin : g_slot
        if (gi < PWM_COUNT) begin : g_chan
            assign w_clr[gi]     = w_clr_cmd & (sel_q == c_SELW'(gi));
            assign w_ovf_clr[gi] = w_stat_rd & (sel_q == c_SELW'(gi));

            pwm_capture_chan #(
                .CW(c_CW)
            ) u_chan (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .pwm_i     (pwm_i[gi]),
                .clr_i     (w_clr[gi]),
                .ovf_clr_i (w_ovf_clr[gi]),
                .level_o   (w_level[gi]),
                .run_o     (w_run[gi]),
                .valid_o   (w_valid[gi]),
                .ovf_o     (w_ovf[gi]),
                .period_o  (w_period[gi]),
                .high_o    (w_high[gi])
            );
        end else begin : g_pad
            assign w_level[gi]  = 1'b0;
            assign w_run[gi]    = 1'b0;
            assign w_valid[gi]  = 1'b0;
            assign w_ovf[gi]    = 1'b0;
            assign w_period[gi] = '0;
            assign w_high[gi]   = '0;
        end
    end

    always_comb begin
        data_d   = data_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        case (pi1_op_i)
            PIWROP: begin
                data_d = c_CLKFREQ;
                if (pi1_data_i[1:0] == CMD_SELECT) begin
                    sel_d = pi1_data_i[c_SELW+1:2];
                end
            end
            PIRDOP: begin
                data_d = ARCHBITSZ'(w_level);
            end
            PIRWOP: begin
                case (pi1_data_i[1:0])
                    RWSEL_PERIOD: begin
                        data_d   = {w_period[sel_q], 2'b00};
                        // Latch high time now so the pair read later is coherent
                        shadow_d = w_high[sel_q];
                    end
                    RWSEL_HIGH: begin
                        data_d = {shadow_q, 2'b00};
                    end
                    RWSEL_STATUS: begin
                        data_d = ARCHBITSZ'({w_ovf[sel_q], w_valid[sel_q],
                                             w_level[sel_q], w_run[sel_q]});
                    end
                    default: begin
                        data_d = '0;
                    end
                endcase
            end
            default: begin
                data_d = data_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sel_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
        end
    end

    assign pi1_data_o  = data_q;
    assign pi1_rdy_o   = 1'b1;
    assign pi1_mapsz_o = ADDRBITSZ'(1);

    // Address, byte selects and upper command bits carry no meaning here
    assign w_unused = ^{pi1_addr_i, pi1_sel_i, pi1_data_i};

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pwm_capture                                                  |
// | Purpose  : Self-checking bench for pwm_capture. A 32-bit instance and a    |
// |            10-bit instance are driven with directed PWM waveforms; a      |
// |            timestamp-based model predicts every bus response.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pwm_capture;

    localparam logic [1:0] NOP = 2'b00, WR = 2'b01, RD = 2'b10, RW = 2'b11;
    localparam int CLKF0 = 12345678;
    localparam int CLKF1 = 100;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  op0, op1;
    logic [31:0] d0, q0;
    logic [9:0]  d1, q1;
    logic [29:0] addr0 = '0, map0;
    logic [9:0]  addr1 = '0, map1;
    logic [3:0]  bsel0 = '0;
    logic [0:0]  bsel1 = '0;
    logic        rdy0, rdy1;
    logic [7:0]  pwm0, pwm1;
    logic [7:0]  gen_val = '0, gen_on = '0, man0 = '0, man1 = '0;

    int gp [8];
    int gh [8];
    int gph[8];

    int n_tests = 0;
    int n_fail  = 0;

    assign pwm0 = (gen_val & gen_on) | (man0 & ~gen_on);
    assign pwm1 = man1;

    always #5 clk = ~clk;

    pwm_capture #(.PWM_COUNT(8), .CLKFREQ(CLKF0), .ARCHBITSZ(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .pi1_op_i(op0), .pi1_addr_i(addr0),
        .pi1_data_i(d0), .pi1_data_o(q0), .pi1_sel_i(bsel0), .pi1_rdy_o(rdy0),
        .pi1_mapsz_o(map0), .pwm_i(pwm0)
    );

    pwm_capture #(.PWM_COUNT(8), .CLKFREQ(CLKF1), .ARCHBITSZ(10)) dut_small (
        .clk_i(clk), .rst_i(rst_i), .pi1_op_i(op1), .pi1_addr_i(addr1),
        .pi1_data_i(d1), .pi1_data_o(q1), .pi1_sel_i(bsel1), .pi1_rdy_o(rdy1),
        .pi1_mapsz_o(map1), .pwm_i(pwm1)
    );

    // Waveform generator for the 32-bit instance: period gp, high gh
    always @(negedge clk) begin
        for (int c = 0; c < 8; c++) begin
            if (gen_on[c]) begin
                gen_val[c] = (gph[c] < gh[c]);
                gph[c]     = (gph[c] + 1) % gp[c];
            end
        end
    end

    // ---------------- behavioural model ----------------
    // Pin samples pass a 3-deep history ([0] newest); a rise is acted on when
    // the middle sample is 1 and the oldest is 0. Measurements are differences
    // between edge timestamps, capped at the counter limit.
    bit          mh   [2][8][3];
    bit          mrun [2][8];
    longint      mts  [2][8];
    longint      mper [2][8];
    longint      mhigh[2][8];
    bit          mval [2][8];
    bit          movf [2][8];
    int          msel [2];
    longint      msh  [2];
    logic [31:0] mexp [2];
    longint      cyc = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 8; c++) begin
                for (int k = 0; k < 3; k++) mh[i][c][k] = 1'b0;
                mrun[i][c] = 0; mts[i][c] = 0; mper[i][c] = 0; mhigh[i][c] = 0;
                mval[i][c] = 0; movf[i][c] = 0;
            end
            msel[i] = 0; msh[i] = 0; mexp[i] = '0;
        end
    endtask

    task automatic model_step(input int i, input logic [1:0] op,
                              input logic [31:0] d, input logic [7:0] pin);
        longint      mx;
        longint      dt;
        logic [31:0] r;
        int          s;
        int          clr_ch;
        bit          clr_st;
        bit          rise, fall;
        bit          set_ovf[8];
        mx     = (i == 0) ? 64'd1073741823 : 64'd255;
        s      = msel[i];
        r      = mexp[i];
        clr_ch = -1;
        clr_st = 0;
        case (op)
            WR: begin
                r = (i == 0) ? CLKF0 : CLKF1;
                if (d[1:0] == 2'b01) clr_ch = s;
            end
            RD: begin
                r = '0;
                for (int c = 0; c < 8; c++) r[c] = mh[i][c][1];
            end
            RW: begin
                case (d[1:0])
                    2'b00: begin r = 32'(mper[i][s] * 4); msh[i] = mhigh[i][s]; end
                    2'b01: r = 32'(msh[i] * 4);
                    2'b10: begin
                        r = '0;
                        r[3] = movf[i][s]; r[2] = mval[i][s];
                        r[1] = mh[i][s][1]; r[0] = mrun[i][s];
                        clr_st = 1;
                    end
                    default: r = '0;
                endcase
            end
            default: ;
        endcase
        for (int c = 0; c < 8; c++) begin
            rise = mh[i][c][1] & ~mh[i][c][2];
            fall = ~mh[i][c][1] & mh[i][c][2];
            set_ovf[c] = 0;
            if (mrun[i][c]) begin
                dt = cyc - mts[i][c];
                if (rise) begin
                    if (dt - 1 >= mx) begin
                        mper[i][c] = mx; movf[i][c] = 1; set_ovf[c] = 1;
                    end else begin
                        mper[i][c] = dt;
                    end
                    mval[i][c] = 1;
                    mts[i][c]  = cyc;
                end else begin
                    if (fall) mhigh[i][c] = (dt > mx) ? mx : dt;
                    if (!fall && dt - 1 >= mx) begin
                        mrun[i][c] = 0; mper[i][c] = 0; mhigh[i][c] = 0;
                        mval[i][c] = 0; movf[i][c] = 1; set_ovf[c] = 1;
                    end
                end
            end else if (rise) begin
                mrun[i][c] = 1;
                mts[i][c]  = cyc;
            end
            mh[i][c][2] = mh[i][c][1];
            mh[i][c][1] = mh[i][c][0];
            mh[i][c][0] = pin[c];
        end
        if (clr_ch >= 0) begin
            mrun[i][clr_ch] = 0; mval[i][clr_ch] = 0; movf[i][clr_ch] = 0;
        end
        if (clr_st && !set_ovf[s]) movf[i][s] = 0;
        if (op == WR && d[1:0] == 2'b00) msel[i] = int'(d[4:2]);
        mexp[i] = (i == 0) ? r : (r & 32'h3FF);
    endtask

    always @(posedge clk) begin
        if (!rst_i) begin
            model_reset();
        end else begin
            model_step(0, op0, d0, pwm0);
            model_step(1, op1, {22'd0, d1}, pwm1);
            cyc++;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: both instances' responses must match the model
    always @(negedge clk) begin
        check("data_o big vs model", q0, mexp[0]);
        check("data_o small vs model", {22'd0, q1}, mexp[1]);
    end

    task automatic bus0(input logic [1:0] op, input logic [31:0] d, output logic [31:0] r);
        @(negedge clk); op0 = op; d0 = d;
        @(negedge clk); op0 = NOP; d0 = '0; r = q0;
    endtask

    task automatic bus1(input logic [1:0] op, input logic [9:0] d, output logic [9:0] r);
        @(negedge clk); op1 = op; d1 = d;
        @(negedge clk); op1 = NOP; d1 = '0; r = q1;
    endtask

    task automatic pulse0(input int hi, input int lo);
        man0[0] = 1'b1;
        repeat (hi) @(negedge clk);
        man0[0] = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulse1(input int hi, input int lo);
        man1[0] = 1'b1;
        repeat (hi) @(negedge clk);
        man1[0] = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, r2;
        logic [9:0]  s;
        for (int c = 0; c < 8; c++) begin gp[c] = 1; gh[c] = 0; gph[c] = 0; end
        rst_i = 1'b0;
        op0 = NOP; d0 = '0; op1 = NOP; d1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset data_o", q0, 32'h0);
        check("reset data_o small", {22'd0, q1}, 32'h0);
        check("rdy", {31'd0, rdy0}, 32'h1);
        check("mapsz", {2'd0, map0}, 32'h1);
        rst_i = 1'b1;

        // WR returns the clock frequency (command 10 is otherwise ignored)
        bus0(WR, 32'h2, r);
        check("wr clkfreq", r, CLKF0);
        bus1(WR, 10'h2, s);
        check("wr clkfreq small", {22'd0, s}, CLKF1);

        // Channel 5: period 4, high 1; channel 0 idle
        gp[5] = 4; gh[5] = 1; gph[5] = 0; gen_on[5] = 1'b1;
        bus0(WR, (32'd5 << 2), r);
        repeat (20) @(negedge clk);
        bus0(RW, 32'h0, r);
        check("ch5 period", r, 32'd4 << 2);
        bus0(RW, 32'h1, r);
        check("ch5 high", r, 32'd1 << 2);
        bus0(WR, 32'h0, r);
        bus0(RW, 32'h0, r);
        check("ch0 idle period", r, 32'h0);

        // Channel 0: 3 high / 7 low
        gp[0] = 10; gh[0] = 3; gph[0] = 0; gen_on[0] = 1'b1;
        repeat (40) @(negedge clk);
        bus0(RW, 32'h0, r);
        check("ch0 period", r, 32'd10 << 2);
        bus0(RW, 32'h1, r);
        check("ch0 high", r, 32'd3 << 2);
        bus0(RW, 32'h2, r);
        check("ch0 status ovf/valid/run", r & 32'hD, 32'h5);

        // RD returns synchronised pin levels
        gen_on = '0; man0 = 8'hA5;
        repeat (3) @(negedge clk);
        bus0(RD, 32'h0, r);
        check("rd pins", r, 32'hA5);

        // Rise acted on in the same cycle as a period read
        man0 = '0;
        repeat (5) @(negedge clk);
        bus0(WR, 32'h1, r);
        repeat (3) @(negedge clk);
        pulse0(2, 4);
        pulse0(2, 7);
        man0[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        op0 = RW; d0 = 32'h0;
        @(negedge clk);
        r = q0;
        @(negedge clk);
        r2 = q0;
        op0 = NOP;
        check("race read old period", r, 32'd6 << 2);
        check("race read new period", r2, 32'd9 << 2);
        bus0(RW, 32'h1, r);
        check("race shadow high", r, 32'd2 << 2);
        man0[0] = 1'b0;

        // Small instance: one pulse, then input stuck high until overflow
        pulse1(3, 5);
        man1[0] = 1'b1;
        repeat (300) @(negedge clk);
        bus1(RW, 10'h2, s);
        check("ovf status", {22'd0, s}, 32'hA);
        bus1(RW, 10'h0, s);
        check("ovf period", {22'd0, s}, 32'h0);
        bus1(RW, 10'h2, s);
        check("ovf status after clear", {22'd0, s}, 32'h2);

        // Asynchronous reset in the middle of a measurement
        gp[0] = 10; gh[0] = 3; gph[0] = 0; gen_on[0] = 1'b1;
        repeat (40) @(negedge clk);
        bus0(RW, 32'h0, r);
        check("pre-reset period", r, 32'd10 << 2);
        @(posedge clk);
        #3;
        rst_i = 1'b0;
        model_reset();
        #1;
        check("async reset data_o", q0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        bus0(RW, 32'h2, r);
        check("post-reset status", r, 32'h0);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
